// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer producing one datapath control word per clock.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        con_output,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        con_enable,
  output logic        ram_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        r_enable,
  output logic        r_select,
  output logic        BAout,
  output logic        PC_select,
  output logic        HI_select,
  output logic        LO_select,
  output logic        Z_HI_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        InPort_select,
  output logic        c_select,
  output logic [4:0]  alu_instruction,
  output logic        run
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  state_t r_state, w_next;
  logic [4:0] w_op;
  logic w_ld, w_ldi, w_st, w_rt, w_imm, w_br, w_mfhi, w_mflo, w_halt, w_mem, w_addr;
  assign w_op   = IR_Data[31:27];
  assign w_ld   = w_op == 5'd0;
  assign w_ldi  = w_op == 5'd1;
  assign w_st   = w_op == 5'd2;
  assign w_rt   = w_op >= 5'd3 && w_op <= 5'd11;
  assign w_imm  = w_op >= 5'd12 && w_op <= 5'd14;
  assign w_br   = w_op == 5'd19;
  assign w_mfhi = w_op == 5'd24;
  assign w_mflo = w_op == 5'd25;
  assign w_halt = w_op == 5'd27;
  assign w_mem  = w_ld | w_st;
  assign w_addr = w_ldi | w_mem;
  always_ff @(posedge clk or posedge clr)
    if (clr) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = T0;
      T0:   w_next = T1;
      T1:   w_next = T2;
      T2:   w_next = T3;
      T3:   w_next = w_halt ? HALT : (w_rt | w_imm | w_addr | w_br) ? T4 : T0;
      T4:   w_next = T5;
      T5:   w_next = (w_mem | w_br) ? T6 : T0;
      T6:   w_next = w_br ? T0 : T7;
      T7:   w_next = T0;
      default: w_next = HALT;
    endcase
  end
  always_comb begin
    {PC_enable, PC_increment_enable, IR_enable, con_enable, ram_enable, Y_enable,
     Z_enable, MAR_enable, MDR_enable, HI_enable, LO_enable, read, write} = '0;
    {Gra, Grb, Grc, r_enable, r_select, BAout} = '0;
    {PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select, MDR_select,
     InPort_select, c_select} = '0;
    alu_instruction = 5'd0;
    run = r_state != HALT;
    case (r_state)
      T0: {PC_select, MAR_enable, PC_increment_enable} = 3'b111;
      T1: {ram_enable, read, MDR_enable} = 3'b111;
      T2: {MDR_select, IR_enable} = 2'b11;
      T3: begin
        Gra        = w_br | w_mfhi | w_mflo;
        Grb        = w_rt | w_imm | w_addr;
        r_select   = w_rt | w_imm | w_br;
        BAout      = w_addr;
        Y_enable   = w_rt | w_imm | w_addr;
        con_enable = w_br;
        HI_select  = w_mfhi;
        LO_select  = w_mflo;
        r_enable   = w_mfhi | w_mflo;
      end
      T4: begin
        Grc             = w_rt;
        r_select        = w_rt;
        Z_enable        = w_rt | w_imm | w_addr;
        c_select        = w_imm | w_addr;
        PC_select       = w_br;
        Y_enable        = w_br;
        alu_instruction = w_rt ? w_op : w_imm ? (w_op == 5'd12 ? 5'd3 : w_op == 5'd13 ? 5'd5 : 5'd6) :
                          w_addr ? 5'd3 : 5'd0;
      end
      T5: begin
        Z_LO_select     = w_rt | w_imm | w_addr;
        Gra             = w_rt | w_imm | w_ldi;
        r_enable        = w_rt | w_imm | w_ldi;
        MAR_enable      = w_mem;
        c_select        = w_br;
        Z_enable        = w_br;
        alu_instruction = w_br ? 5'd3 : 5'd0;
      end
      T6: begin
        ram_enable  = w_ld;
        read        = w_ld;
        MDR_enable  = w_mem;
        Gra         = w_st;
        r_select    = w_st;
        Z_LO_select = w_br & con_output;
        PC_enable   = w_br & con_output;
      end
      T7: begin
        MDR_select = w_ld;
        Gra        = w_ld;
        r_enable   = w_ld;
        ram_enable = w_st;
        write      = w_st;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore control sequencer that drives the datapath control inputs: register enables, bus-source selects, memory strobes and the ALU opcode. It reads the opcode from the datapath `IR_Data` output and the branch flag from the CON FF. It steps each instruction through fetch and execute micro-steps, emitting one control word per clock. It sits beside the datapath at CPU top level and is the producer of every select and enable signal the datapath consumes.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `clr`  in  1  asynchronous active-high reset.
- `IR_Data`  in  32  current instruction; opcode is `IR_Data[31:27]`.
- `con_output`  in  1  branch-condition flag from CON FF.
- `PC_enable`, `PC_increment_enable`, `IR_enable`, `con_enable`, `ram_enable`, `Y_enable`, `Z_enable`, `MAR_enable`, `MDR_enable`, `HI_enable`, `LO_enable`  out  1 each  datapath register and RAM enables.
- `read`, `write`  out  1 each  memory read (also MDR source mux) and write strobes.
- `Gra`, `Grb`, `Grc`, `r_enable`, `r_select`, `BAout`  out  1 each  select-and-encode controls.
- `PC_select`, `HI_select`, `LO_select`, `Z_HI_select`, `Z_LO_select`, `MDR_select`, `InPort_select`, `c_select`  out  1 each  bus-source selects; at most one high per cycle.
- `alu_instruction`  out  5  ALU opcode.
- `run`  out  1  high unless halted.

## Operation
- States: IDLE, T0–T7, HALT. The state register is the only storage.
- All outputs are decoded combinationally from state and opcode. Every output not listed for a step is 0. `alu_instruction` is 0 except in steps that assert `Z_enable`.
- Fetch (all opcodes):
  - T0: `PC_select`, `MAR_enable`, `PC_increment_enable`.
  - T1: `ram_enable`, `read`, `MDR_enable`.
  - T2: `MDR_select`, `IR_enable`.
- Opcodes: ld 00000, ldi 00001, st 00010, R-type ALU 00011–01011, addi 01100, andi 01101, ori 01110, br 10011, mfhi 11000, mflo 11001, halt 11011. Every other opcode is a nop.
- R-type:
  - T3: `Grb`, `r_select`, `Y_enable`.
  - T4: `Grc`, `r_select`, `Z_enable`, alu = opcode.
  - T5: `Z_LO_select`, `Gra`, `r_enable`; then T0.
- addi/andi/ori:
  - T3: as R-type.
  - T4: `c_select`, `Z_enable`, alu = 00011 / 00101 / 00110 respectively.
  - T5: as R-type.
- ldi:
  - T3: `Grb`, `BAout`, `Y_enable`.
  - T4: `c_select`, `Z_enable`, alu 00011.
  - T5: `Z_LO_select`, `Gra`, `r_enable`; then T0.
- ld:
  - T3–T4: as ldi.
  - T5: `Z_LO_select`, `MAR_enable`.
  - T6: `ram_enable`, `read`, `MDR_enable`.
  - T7: `MDR_select`, `Gra`, `r_enable`; then T0.
- st:
  - T3–T5: as ld.
  - T6: `Gra`, `r_select`, `MDR_enable` (`read`=0, so MDR loads from the bus).
  - T7: `ram_enable`, `write`; then T0.
- br:
  - T3: `Gra`, `r_select`, `con_enable`.
  - T4: `PC_select`, `Y_enable`.
  - T5: `c_select`, `Z_enable`, alu 00011.
  - T6: if `con_output`=1, `Z_LO_select` and `PC_enable`; otherwise nothing. Then T0.
  - `con_output` is sampled combinationally in T6 only.
- mfhi / mflo:
  - T3: `HI_select` / `LO_select`, `Gra`, `r_enable`; then T0.
- nop: T3 asserts nothing; then T0.
- halt: T3 goes to HALT. HALT drives all outputs 0 and `run`=0, and stays there until `clr`.
- IDLE drives all outputs 0 and `run`=1; its next state is T0.

## Timing
- `clr` high forces IDLE immediately, including mid-instruction. All outputs go 0 combinationally and `run`=1. No partial memory write completes after `clr`.
- First T0 occurs on the first rising edge after `clr` deasserts, plus one cycle in IDLE.
- Each step lasts exactly one clock; there are no wait states.
- The opcode is decoded from `IR_Data`, which updates at the end of T2; T3 onward uses the new IR.
- Instruction latency in cycles: R/I/ldi 6, ld/st 8, br 7, mfhi/mflo/nop 4.

## Test plan
- Reset: assert `clr` mid-T4 of add -> all outputs 0 that cycle; after release, IDLE for one cycle, then T0 with `PC_select`=`MAR_enable`=`PC_increment_enable`=1.
- add, IR=0x18000000 (opcode 00011) -> T4 `alu_instruction`=00011 with `Grc`, `r_select`, `Z_enable`; T5 `Z_LO_select`, `Gra`, `r_enable`; next T0 six cycles after the prior T0.
- ori, IR opcode 01110 -> T4 `c_select`=1, `alu_instruction`=00110.
- st, IR opcode 00010 -> T6 `MDR_enable`=1 with `read`=0; T7 `write`=`ram_enable`=1; total 8 cycles.
- br, opcode 10011 -> with `con_output`=1, T6 `PC_enable`=`Z_LO_select`=1; with `con_output`=0, T6 all 0; both return to T0.
- halt, opcode 11011 -> after T3, `run`=0 and all outputs 0 for 20+ cycles; `clr` pulse -> `run`=1, IDLE, then T0.
